vga_pixel_scheduler: RTL
========================

# vga_pixel_scheduler

Frame-level controller that sequences the `wb_data` pixel byte stream feeding `vga_driver`. It shares that single pixel path between two requesters: a full-frame background source and a rectangular overlay-window source. It locks the driver's counters with the `2'b11` sync code, tracks the beam position in lockstep, and pops each source through a valid/ready handshake. Underruns are counted.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `LINE_LEN`, 800, total clocks per line (≤1024)
- `V_ACTIVE`, 480, active lines per frame
- `FRAME_LEN`, 525, total lines per frame (≤1024)
- `clk_pix`  in  1  pixel clock; only clock
- `rst_pix`  in  1  reset; synchronous, active-high
- `enable`  in  1  run request
- `win_x0`, `win_x1`  in  10  overlay columns, start inclusive / end exclusive
- `win_y0`, `win_y1`  in  10  overlay lines, start inclusive / end exclusive
- `bg_data`  in  6  background pixel {r[1:0],g[1:0],b[1:0]}
- `bg_valid`  in  1  background pixel available
- `bg_ready`  out  1  background pixel consumed this cycle
- `ov_data`  in  6  overlay pixel, same format
- `ov_valid`  in  1  overlay pixel available
- `ov_ready`  out  1  overlay pixel consumed this cycle
- `wb_data`  out  8  to driver: {rgb[5:0], ctl[1:0]}; ctl=`2'b11` resets driver counters
- `frame_start`  out  1  one-cycle pulse at (hx=0, vy=0) of every frame
- `underrun_cnt`  out  16  saturating count of starved active pixels

## Operation
- States: IDLE, SYNC, RUN.
- **IDLE** (reset state)
  - `wb_data`=8'h03 every cycle, which holds the driver at (0,0).
  - Readies are 0 and `frame_start` is 0.
  - `enable`=1 moves the block to SYNC.
- **SYNC** (one cycle)
  - `wb_data`=8'h03.
  - Latches the window registers, sets hx=0 and vy=0, and moves to RUN.
- **RUN**
  - Internal hx and vy are 10-bit counters. hx advances every cycle and wraps at `LINE_LEN`-1. vy increments on each hx wrap and wraps at `FRAME_LEN`-1.
  - The value on `wb_data` in the cycle with (hx,vy) is the pixel for that position.
  - **Active pixel** (hx<`H_ACTIVE` and vy<`V_ACTIVE`):
    - `bg_ready`=1 always, so the background stream is full-frame and overlaid pixels are discarded.
    - In-window means latched x0≤hx<x1 and y0≤vy<y1. In-window pixels also assert `ov_ready`=1.
    - Selection when in-window: `ov_data` if `ov_valid`; else `bg_data` if `bg_valid`; else black.
    - Selection when out-of-window: `bg_data` if `bg_valid`; else black.
    - `wb_data`={selected,2'b00}.
    - Black output means starved: `underrun_cnt`+1, saturating at 16'hFFFF.
  - **Blanking:** `wb_data`=8'h00 and both readies are 0.
  - **Last cycle of frame** (hx=`LINE_LEN`-1, vy=`FRAME_LEN`-1):
    - `wb_data`=8'h03, which resynchronises the driver identically to its natural wrap.
    - Window registers are relatched from the inputs.
    - If `enable`=0, the next state is IDLE; otherwise RUN continues with hx=vy=0.
- `ctl` is never `2'b11` in RUN except on the last cycle of the frame.
- A window with x1≤x0 or y1≤y0 is empty, so `ov_ready` is never asserted.
- Window inputs changed mid-frame take effect on the next frame only.
- `enable` deasserted mid-frame: the frame completes, then the block enters IDLE.
- Ready signals are asserted regardless of valid. A source whose valid is low loses nothing, because no transfer occurs.

## Timing
- `wb_data`, `bg_ready`, `ov_ready` are combinational from registered state plus the current-cycle valid/data inputs. The driver registers `wb_data` on the next `clk_pix` edge.
- Transfer occurs when ready&&valid at a rising edge.
- From the first cycle in IDLE with `enable`=1:
  - the next cycle is SYNC;
  - the cycle after that is pixel (0,0) with `frame_start`=1.
- `underrun_cnt`, hx, vy and state update on the rising edge.
- Reset values: state IDLE, hx=vy=0, window registers 0, `underrun_cnt`=0, `wb_data`=8'h03, readies 0, `frame_start`=0.
- Reset asserted mid-frame takes effect at the next edge. The next cycle outputs 8'h03, and any in-flight handshake is abandoned.

## Test plan
- Reset, then `enable`=0 for 20 cycles → `wb_data`=8'h03, both readies 0, `underrun_cnt`=0 throughout.
- `enable`=1, `bg_valid`=1, `bg_data`=6'h3F, empty window:
  - one SYNC cycle with 8'h03;
  - then `frame_start` pulses;
  - hx 0..639 on line 0: `wb_data`=8'hFC with `bg_ready`=1;
  - hx 640..799: 8'h00 with `bg_ready`=0;
  - cycle (799,524): 8'h03;
  - `frame_start` again 420000 cycles after the first.
- Window (100,200,50,60), `ov_valid`=1, `ov_data`=6'h30, bg 6'h0C:
  - (99,50) → 8'h30;
  - (100,50) → 8'hC0 with both readies high;
  - (200,50) → 8'h30;
  - (100,60) → 8'h30.
- Within the same window:
  - `ov_valid`=0 at (150,55) → falls back to bg 8'h30, no underrun;
  - both valids 0 at (5,0) → 8'h00 and `underrun_cnt`=1;
  - starve an entire frame → count saturates at 16'hFFFF and never wraps.
- Change window inputs at (0,10) → no effect until the cycle after (799,524).
- Drop `enable` at (0,100) → the frame completes, then 8'h03 steady. Reassert `enable` → SYNC, then `frame_start`.
- Assert `rst_pix` at (300,200) → the next cycle shows 8'h03, readies 0, state IDLE, and `underrun_cnt`=0.

Source files
------------

// File: rtl/vga_pixel_scheduler_if.sv
// Pixel-stream bundle shared by the scheduler, its two pixel sources and vga_driver.
`timescale 1ns/1ps
interface vga_pixel_scheduler_if;
   logic        enable;
   logic [9:0]  win_x0;
   logic [9:0]  win_x1;
   logic [9:0]  win_y0;
   logic [9:0]  win_y1;
   logic [5:0]  bg_data;
   logic        bg_valid;
   logic        bg_ready;
   logic [5:0]  ov_data;
   logic        ov_valid;
   logic        ov_ready;
   logic [7:0]  wb_data;
   logic        frame_start;
   logic [15:0] underrun_cnt;

   // Scheduler side: consumes the sources, drives the driver byte stream.
   modport master (
      input  enable, win_x0, win_x1, win_y0, win_y1,
      input  bg_data, bg_valid, ov_data, ov_valid,
      output bg_ready, ov_ready, wb_data, frame_start, underrun_cnt
   );

   // Environment side: sources, window control and the driver.
   modport slave (
      output enable, win_x0, win_x1, win_y0, win_y1,
      output bg_data, bg_valid, ov_data, ov_valid,
      input  bg_ready, ov_ready, wb_data, frame_start, underrun_cnt
   );
endinterface

// File: rtl/vga_pixel_scheduler.sv
// Frame-level scheduler for the vga_driver pixel byte stream: merges a full-frame
// background source with a rectangular overlay window, tracks the beam in lockstep
// with the driver and counts starved active pixels.
`timescale 1ns/1ps
module vga_pixel_scheduler #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned LINE_LEN  = 800,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned FRAME_LEN = 525
) (
   input  logic                  clk_pix,
   input  logic                  rst_pix,
   vga_pixel_scheduler_if.master bus
);
   localparam logic [9:0] HX_LAST = 10'(LINE_LEN - 1);
   localparam logic [9:0] VY_LAST = 10'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [9:0]  r_hx;
   logic [9:0]  r_vy;
   logic [9:0]  r_win_x0;
   logic [9:0]  r_win_x1;
   logic [9:0]  r_win_y0;
   logic [9:0]  r_win_y1;
   logic [15:0] r_underrun;
   logic        w_last;
   logic        w_active;
   logic        w_in_win;
   logic        w_starve;
   logic [5:0]  w_pix;

   // Beam-position decode: last cycle of frame, active area, overlay window hit.
   always_comb begin
      w_last   = (r_hx == HX_LAST) && (r_vy == VY_LAST);
      w_active = (32'(r_hx) < H_ACTIVE) && (32'(r_vy) < V_ACTIVE);
      w_in_win = (r_hx >= r_win_x0) && (r_hx < r_win_x1) &&
                 (r_vy >= r_win_y0) && (r_vy < r_win_y1);
   end

   // Next state, pixel selection and handshake outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_pix           = '0;
      w_starve        = 1'b0;
      bus.wb_data     = 8'h03;
      bus.bg_ready    = 1'b0;
      bus.ov_ready    = 1'b0;
      bus.frame_start = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.enable) w_state_nxt = SYNC;
         end
         SYNC: begin
            w_state_nxt = RUN;
         end
         RUN: begin
            bus.frame_start = (r_hx == '0) && (r_vy == '0);
            if (w_last) begin
               // wb_data keeps the 8'h03 default: resync code matching the driver wrap
               if (!bus.enable) w_state_nxt = IDLE;
            end else if (w_active) begin
               bus.bg_ready = 1'b1;
               bus.ov_ready = w_in_win;
               if (w_in_win && bus.ov_valid) w_pix = bus.ov_data;
               else if (bus.bg_valid)        w_pix = bus.bg_data;
               else                          w_starve = 1'b1;
               bus.wb_data = {w_pix, 2'b00};
            end else begin
               bus.wb_data = 8'h00;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register and beam counters.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_state <= IDLE;
         r_hx    <= '0;
         r_vy    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == SYNC) begin
            r_hx <= '0;
            r_vy <= '0;
         end else if (r_state == RUN) begin
            if (r_hx == HX_LAST) begin
               r_hx <= '0;
               r_vy <= (r_vy == VY_LAST) ? '0 : r_vy + 10'd1;
            end else begin
               r_hx <= r_hx + 10'd1;
            end
         end
      end
   end

   // Window registers sampled only at frame boundaries so mid-frame edits wait a frame.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_win_x0 <= '0;
         r_win_x1 <= '0;
         r_win_y0 <= '0;
         r_win_y1 <= '0;
      end else if ((r_state == SYNC) || ((r_state == RUN) && w_last)) begin
         r_win_x0 <= bus.win_x0;
         r_win_x1 <= bus.win_x1;
         r_win_y0 <= bus.win_y0;
         r_win_y1 <= bus.win_y1;
      end
   end

   // Saturating count of active pixels sent as black for lack of source data.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_underrun <= '0;
      end else if (w_starve && (r_underrun != '1)) begin
         r_underrun <= r_underrun + 16'd1;
      end
   end

   assign bus.underrun_cnt = r_underrun;
endmodule
